// File: rtl/tt_arith_pkg.sv
// Shared definitions for the TinyTapeout serial arithmetic blocks:
// FSM state encoding and the default operand width.
package tt_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_SHIFT = 2'd1;
    localparam logic [1:0] ENC_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_SHIFT = ENC_SHIFT,
        ST_DONE  = ENC_DONE
    } serial_state_t;

endpackage

// File: rtl/full_subtractor_cell.sv
// Single-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    logic w_axb;

    assign w_axb  = i_a ^ i_b;
    assign o_d    = w_axb ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~w_axb & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: captures a and b on start, produces a - b LSB first
// through one full-subtractor cell, then publishes diff/borrow with a done pulse.
module serial_subtractor
    import tt_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    serial_state_t    r_state;
    serial_state_t    w_state_next;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_d_sr;
    logic             r_bin;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_done;

    logic             w_d;
    logic             w_bout;
    logic             w_last_bit;

    full_subtractor_cell u_cell (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_bin  (r_bin),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    assign w_last_bit = (r_cnt == LAST_BIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the next state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last_bit) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: the shift registers and counter are cleared on reset too, so an
    // aborted operation leaves no stale partial result behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_d_sr   <= '0;
            r_bin    <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sr <= a;
                        r_b_sr <= b;
                        r_bin  <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_d_sr <= {w_d, r_d_sr[WIDTH-1:1]};
                    r_bin  <= w_bout;
                    if (!w_last_bit) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Results become visible only here, never mid-operation.
                    r_diff   <= r_d_sr;
                    r_borrow <= r_bin;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases plus
// random operands against a plain-arithmetic reference.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: unsigned subtraction widened by one bit; bit W is the borrow.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} - {1'b0, y};
    endfunction

    // Starts at a negedge with the DUT idle; returns at the negedge where done
    // is seen (or after the cycle budget). lat counts cycles after acceptance.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input bit poke, output int lat, output int busy_n);
        logic [W-1:0] held_diff;
        logic         held_borrow;
        int           hold_bad;
        held_diff   = diff;
        held_borrow = borrow;
        hold_bad    = 0;
        lat         = -1;
        busy_n      = 0;
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        for (int m = 0; m < 20 && lat < 0; m++) begin
            @(negedge clk);
            if (poke && m == 3) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h01;
            end
            if (poke && m == 4) start = 1'b0;
            if (busy) busy_n++;
            if (done) lat = m;
            else if (diff !== held_diff || borrow !== held_borrow) hold_bad++;
        end
        check("hold_until_done", hold_bad, 0);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    task automatic directed(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b);
        int lat;
        int busy_n;
        logic [W:0] exp;
        exp = ref_sub(op_a, op_b);
        run_op(op_a, op_b, 1'b0, lat, busy_n);
        check({tag, "_lat"}, lat, 9);
        check({tag, "_busy"}, busy_n, 9);
        check({tag, "_diff"}, diff, exp[W-1:0]);
        check({tag, "_borrow"}, borrow, exp[W]);
    endtask

    initial begin
        int lat;
        int busy_n;
        int n_done;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W:0]   exp;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_diff", diff, 0);
        check("reset_borrow", borrow, 0);
        rst = 1'b0;
        @(negedge clk);

        directed("p05_03", 8'h05, 8'h03);
        check("p05_03_exact", {borrow, diff}, 9'h002);
        @(negedge clk);
        directed("p03_05", 8'h03, 8'h05);
        check("p03_05_exact", {borrow, diff}, 9'h1FE);
        @(negedge clk);

        // Back-to-back: second start issued in the done cycle.
        directed("p00_ff", 8'h00, 8'hFF);
        check("p00_ff_exact", {borrow, diff}, 9'h101);
        directed("b2b_ff_ff", 8'hFF, 8'hFF);
        check("b2b_ff_ff_exact", {borrow, diff}, 9'h000);
        @(negedge clk);

        // start pulsed mid-SHIFT must be ignored.
        run_op(8'h40, 8'h15, 1'b1, lat, busy_n);
        check("poke_lat", lat, 9);
        check("poke_diff", diff, 8'h2B);
        check("poke_borrow", borrow, 0);
        count_dones(15, n_done);
        check("poke_single_done", n_done, 0);
        check("poke_diff_kept", diff, 8'h2B);
        check("poke_busy_idle", busy, 0);

        // Reset in cycle 4 of SHIFT aborts; outputs return to zero.
        a     = 8'h10;
        b     = 8'h20;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        count_dones(15, n_done);
        check("abort_no_done", n_done, 0);
        check("abort_stays_idle", busy, 0);

        // rst together with start in IDLE: stays idle.
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h77;
        b     = 8'h11;
        @(negedge clk);
        check("rst_start_busy", busy, 0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_still_idle", busy, 0);
        check("rst_start_diff", diff, 0);

        for (int i = 0; i < 1000; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            exp = ref_sub(ra, rb);
            run_op(ra, rb, 1'b0, lat, busy_n);
            check("rand_lat", lat, 9);
            check("rand_diff", diff, exp[W-1:0]);
            check("rand_borrow", borrow, exp[W]);
            if ($urandom_range(1) == 1) repeat ($urandom_range(3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
